irq_sequencer: RTL

- Machine-level external interrupt controller between the N_SRC platform interrupt lines and the core trap logic.
- Synchronises and latches the sources, masks them with the mie enable vector, and picks one winner by fixed priority.
- Runs a request/acknowledge/return handshake with the core, one trap at a time.
- Supplies the mcause value and a one-cycle capture strobe that the CSR file uses to load mepc/mtval.

---
 rtl/irq_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: machine external interrupt sequencer.
// Ports: i_CLK, i_RSTn, i_MEI, i_MIE, i_CLR_PEND, i_IRQ_ACK,
//   i_MRET -> o_IRQ, o_IRQ_ID, o_MCAUSE, o_TAKE,
//   o_IN_HANDLER, o_PENDING. Macro IRQ_SEQ_EDGE_EN: edge mode.
module irq_sequencer #(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [N_SRC-1:0] i_MEI,
  input  logic [N_SRC-1:0] i_MIE,
  input  logic [N_SRC-1:0] i_CLR_PEND,
  input  logic             i_IRQ_ACK,
  input  logic             i_MRET,
  output logic             o_IRQ,
  output logic [2:0]       o_IRQ_ID,
  output logic [31:0]      o_MCAUSE,
  output logic             o_TAKE,
  output logic             o_IN_HANDLER,
  output logic [N_SRC-1:0] o_PENDING
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [1:0]       state;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] id_mask;
  logic [2:0]       win;
  logic             take_now;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= i_MEI;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign id_mask  = N_SRC'(1) << o_IRQ_ID;
  assign take_now = (state == REQ) && i_IRQ_ACK;
  assign elig     = pend & i_MIE;

`ifdef IRQ_SEQ_EDGE_EN
  logic [N_SRC-1:0] hist;
  logic [N_SRC-1:0] ack_clr;

  // Taking the trap consumes the edge of the winning source.
  assign ack_clr = {N_SRC{take_now}} & id_mask;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      hist <= '0;
      pend <= '0;
    end else begin
      hist <= sync;
      // A new edge beats a clear in the same cycle.
      pend <= (sync & ~hist) |
              (pend & ~i_CLR_PEND & ~ack_clr);
    end
  end
`else
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn)
      pend <= '0;
    else
      pend <= sync & ~i_CLR_PEND;
  end
`endif

  always_comb begin
    win = '0;
    for (int i = N_SRC-1; i >= 0; i--)
      if (elig[i]) win = 3'(i);
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state    <= IDLE;
      o_IRQ_ID <= '0;
      o_MCAUSE <= '0;
      o_TAKE   <= 1'b0;
    end else begin
      o_TAKE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            o_IRQ_ID <= win;
            state    <= REQ;
          end
        end
        REQ: begin
          if (i_IRQ_ACK) begin
            state    <= ACTIVE;
            o_TAKE   <= 1'b1;
            o_MCAUSE <= {1'b1, 23'd0,
                         8'd16 + {5'd0, o_IRQ_ID}};
          end else if (~|(elig & id_mask)) begin
            state <= IDLE;
          end
        end
        ACTIVE: begin
          if (i_MRET) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_IRQ        = (state == REQ);
  assign o_IN_HANDLER = (state == ACTIVE);
  assign o_PENDING    = pend;

endmodule
